data_block: RTL and testbench



---
 rtl/data_block.sv | 47 ++++
 tb/tb_data_block.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/data_block.sv
// data_block: word-addressed 32-bit data memory for the mini MIPS memory stage.
// Combinational read port, synchronous write port. The storage array `memory`
// has no reset so that preloaded contents survive rst_n; only the read port is
// forced to zero while reset is asserted.
module data_block #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    output logic [31:0] readData,
    input  logic [31:0] writeData,
    input  logic [31:0] address,
    input  logic        memWrite,
    input  logic        clk,
    input  logic        rst_n
);

    logic [31:0] memory [0:DEPTH-1];

    // Word index: upper address bits are ignored, so the index wraps modulo DEPTH.
    logic [ADDR_BITS-1:0] index;
    assign index = address[ADDR_BITS-1:0];

    // Upper address bits exist only for port compatibility with the datapath.
    logic unusedAddrBits;
    assign unusedAddrBits = ^address[31:ADDR_BITS];

    // A write needs both reset released and an explicit 1 on memWrite; an
    // unknown enable evaluates false in the if, so it never commits.
    logic writeEn;
    assign writeEn = rst_n & memWrite;

    // Commit the selected word on the rising edge; the array is never cleared.
    always_ff @(posedge clk) begin
        if (writeEn == 1'b1) begin
            memory[index] <= writeData;
        end
    end

    // Zero-latency read, forced to zero asynchronously while in reset.
    always_comb begin
        readData = 32'h0000_0000;
        if (rst_n) begin
            readData = memory[index];
        end
    end

endmodule

// File: tb/tb_data_block.sv
// Testbench for data_block: directed steps plus randomized traffic, checked
// against a plain array model of the word memory.
module tb_data_block;

    localparam int DEPTH = 256;

    logic [31:0] readData;
    logic [31:0] writeData;
    logic [31:0] address;
    logic        memWrite;
    logic        clk;
    logic        rst_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] refMem [DEPTH];

    data_block #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
        .readData (readData),
        .writeData(writeData),
        .address  (address),
        .memWrite (memWrite),
        .clk      (clk),
        .rst_n    (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] a);
        return int'(a % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: drive inputs, check the pre-edge read (old data, no bypass),
    // let one rising edge pass, update the model, check the post-edge read.
    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic we, input string tag);
        address   = a;
        writeData = wd;
        memWrite  = we;
        #1;
        chk({tag, "_pre"}, readData, refMem[idxOf(a)]);
        @(posedge clk);
        if (we) refMem[idxOf(a)] = wd;
        #1;
        chk({tag, "_post"}, readData, refMem[idxOf(a)]);
    endtask

    initial begin
        rst_n     = 1'b0;
        memWrite  = 1'b0;
        address   = 32'd0;
        writeData = 32'd0;
        #2;
        chk("reset_read", readData, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload every word through the write port with random data, then the
        // three known values.
        for (int i = 0; i < DEPTH; i++) op(i, $urandom, 1'b1, "preload");
        op(32'd0,   32'h11111111, 1'b1, "pre0");
        op(32'd8,   32'h88888888, 1'b1, "pre8");
        op(32'd128, 32'hAAAAAAAA, 1'b1, "pre128");

        // Zero-latency reads of the known words.
        memWrite = 1'b0;
        address = 32'd0;   #1; chk("read0",   readData, 32'h11111111);
        address = 32'd8;   #1; chk("read8",   readData, 32'h88888888);
        address = 32'd128; #1; chk("read128", readData, 32'hAAAAAAAA);

        // Repeated write to one word, then a neighbour.
        for (int i = 0; i < 3; i++) op(32'd2, 32'd5, 1'b1, "wr2");
        op(32'd1, 32'd3, 1'b1, "wr1");
        chk("wr2_final", refMem[2], 32'd5);
        address = 32'd2; memWrite = 1'b0; #1; chk("rd2", readData, 32'd5);

        // Wrap-around aliasing.
        op(32'h103, 32'hDEADBEEF, 1'b1, "wrap_wr");
        address = 32'd3;     #1; chk("wrap_rd3",   readData, 32'hDEADBEEF);
        address = 32'h103;   #1; chk("wrap_rd103", readData, 32'hDEADBEEF);
        address = 32'h100;   #1; chk("alias_0",    readData, 32'h11111111);

        // Same-address read/write: old value before the edge, new one after.
        op(32'd4, 32'd7, 1'b1, "set4");
        op(32'd4, 32'd9, 1'b1, "rw4");
        chk("rw4_model", refMem[4], 32'd9);

        // Mid-cycle reset with a pending write to word 5.
        address = 32'd5; writeData = 32'h5A5A5A5A; memWrite = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", readData, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", readData, 32'h0);
        end
        memWrite = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_release", readData, refMem[5]);

        // Unknown write enable must not write (2-state sims see 0).
        op(32'd6, 32'h12345678, 1'b0, "wr_off6");
        memWrite = 1'bx; writeData = 32'hCAFEF00D; address = 32'd6;
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        #1;
        chk("x_enable", readData, refMem[6]);

        // Write-disabled sweep over all words.
        for (int i = 0; i < DEPTH; i++) op(i, 32'hFFFFFFFF, 1'b0, "nowr");

        // Randomized traffic over the full 32-bit address space.
        for (int i = 0; i < 400; i++) begin
            op($urandom, $urandom, 1'($urandom_range(0, 1)), "rand");
        end

        // Final readback of every word against the model.
        memWrite = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            address = i;
            #1;
            chk("final", readData, refMem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
